zpu_sd_bridge: RTL

- Multi-slot bridge between the ZPU firmware I/O registers and the HPS SD block interface. Successor to the single-slot sector-buffer glue.
- Adds NUM_SLOTS independent image slots, a queued mount-report mechanism, per-slot file size storage, a request timeout with an error flag, and busy indication.
- Sits in the emu top level between hps_io (sd_* / img_* signals) and the core's ZPU_IN2/IN3, ZPU_OUT2/OUT3 and ZPU_RD/WR strobes.

---
 rtl/zpu_sd_pkg.sv | 27 ++
 rtl/zpu_sd_bridge_if.sv | 35 +++
 rtl/zpu_sd_bridge_dpram.sv | 35 +++
 rtl/zpu_sd_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zpu_sd_pkg.sv
// Shared constants and types for the ZPU <-> HPS SD bridge.
package zpu_sd_pkg;

    // zpu_status bit positions
    localparam int ST_IO_DONE     = 0;
    localparam int ST_MNT_TOGGLE  = 1;
    localparam int ST_FILENO_LO   = 2;   // 3 bits
    localparam int ST_FILETYPE_LO = 5;   // 2 bits
    localparam int ST_READONLY    = 7;
    localparam int ST_ERR         = 8;
    localparam int ST_BUSY        = 9;

    // zpu_ctrl bit positions
    localparam int CTRL_LBA_SEL  = 0;
    localparam int CTRL_BLOCK_RD = 1;
    localparam int CTRL_BLOCK_WR = 2;
    localparam int CTRL_SLOT_LO  = 3;    // 3 bits

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    typedef logic [2:0] slot_t;

endpackage

// File: rtl/zpu_sd_bridge_if.sv
// HPS-side signal bundle (sd_* block interface and img_* mount reports).
// Handshake: the bridge holds sd_rd[s] or sd_wr[s] high until sd_ack[s]
// rises; the HPS keeps sd_ack[s] high while it moves the sector through the
// buffer, and the transfer is complete when sd_ack[s] falls.
interface zpu_sd_bridge_if #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 9
);
    logic [31:0]          sd_lba;
    logic [NUM_SLOTS-1:0] sd_rd;
    logic [NUM_SLOTS-1:0] sd_wr;
    logic [NUM_SLOTS-1:0] sd_ack;
    logic [ADDR_W-1:0]    sd_buff_addr;
    logic [7:0]           sd_buff_dout;
    logic [7:0]           sd_buff_din;
    logic                 sd_buff_wr;
    logic [NUM_SLOTS-1:0] img_mounted;
    logic                 img_readonly;
    logic [63:0]          img_size;
    logic [7:0]           ioctl_index;

    // bridge side: issues requests, serves buffer reads
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  img_mounted, img_readonly, img_size, ioctl_index
    );

    // HPS side
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output img_mounted, img_readonly, img_size, ioctl_index
    );
endinterface

// File: rtl/zpu_sd_bridge_dpram.sv
// Dual-port sector buffer, 2^ADDR_W x 8, one-cycle read latency on both
// ports. Port a belongs to the HPS, port b to the ZPU.
module zpu_sd_bridge_dpram #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [7:0]        din_a,
    input  logic              we_a,
    output logic [7:0]        dout_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [7:0]        din_b,
    input  logic              we_b,
    output logic [7:0]        dout_b
);
    logic [7:0] mem [2**ADDR_W];

    // storage writes; port b wins a same-address collision
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    // registered read data (contents themselves are never cleared)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
        end
    end
endmodule

// File: rtl/zpu_sd_bridge.sv
// Multi-slot bridge between ZPU firmware I/O registers and the HPS SD block
// interface: sector buffer, block request FSM with timeout, mount queue.
module zpu_sd_bridge
    import zpu_sd_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 9,
    parameter int TIMEOUT_W = 24
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic [31:0]    zpu_ctrl,
    input  logic [31:0]    zpu_data,
    input  logic           zpu_io_wr,
    input  logic           zpu_data_wr,
    input  logic           zpu_data_rd,
    input  logic           zpu_mnt_ack,
    output logic [15:0]    zpu_status,
    output logic [31:0]    zpu_rdata,
    output state_t         fsm_state,
    zpu_sd_bridge_if.master hps
);
    logic  lba_sel, ctrl_rd, ctrl_wr;
    slot_t ctrl_slot;
    assign lba_sel   = zpu_ctrl[CTRL_LBA_SEL];
    assign ctrl_rd   = zpu_ctrl[CTRL_BLOCK_RD];
    assign ctrl_wr   = zpu_ctrl[CTRL_BLOCK_WR];
    assign ctrl_slot = zpu_ctrl[CTRL_SLOT_LO +: 3];

    logic data_wr_q1, data_wr_q2, data_rd_q, block_rd_q, block_wr_q;

    // strobe history for edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            data_wr_q1 <= 1'b0;
            data_wr_q2 <= 1'b0;
            data_rd_q  <= 1'b0;
            block_rd_q <= 1'b0;
            block_wr_q <= 1'b0;
        end else begin
            data_wr_q1 <= zpu_data_wr;
            data_wr_q2 <= data_wr_q1;
            data_rd_q  <= zpu_data_rd;
            block_rd_q <= ctrl_rd;
            block_wr_q <= ctrl_wr;
        end
    end

    logic wr_pulse, rd_fall, block_rd_edge, block_wr_edge, buf_we;
    assign wr_pulse      = data_wr_q1 & ~data_wr_q2;
    assign rd_fall       = data_rd_q & ~zpu_data_rd;
    assign block_rd_edge = ctrl_rd & ~block_rd_q;
    assign block_wr_edge = ctrl_wr & ~block_wr_q;
    assign buf_we        = wr_pulse & ~lba_sel;

    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       lba;
    logic [7:0]        buf_q;

    // LBA register and ZPU buffer pointer; io_wr clear beats any increment
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            buf_addr <= '0;
            lba      <= '0;
        end else begin
            if (wr_pulse && lba_sel) lba <= zpu_data;
            if (zpu_io_wr)               buf_addr <= '0;
            else if (buf_we || rd_fall)  buf_addr <= buf_addr + 1'b1;
        end
    end
    assign hps.sd_lba = lba;

    zpu_sd_bridge_dpram #(.ADDR_W(ADDR_W)) u_buf (
        .clk    (clk_sys),
        .rst    (reset),
        .addr_a (hps.sd_buff_addr),
        .din_a  (hps.sd_buff_dout),
        .we_a   (hps.sd_buff_wr),
        .dout_a (hps.sd_buff_din),
        .addr_b (buf_addr),
        .din_b  (zpu_data[7:0]),
        .we_b   (buf_we),
        .dout_b (buf_q)
    );

    // ---------------- block request FSM ----------------
    state_t                state, state_n;
    slot_t                 slot_r, slot_n;
    logic                  rd_req, rd_req_n, wr_req, wr_req_n;
    logic                  io_done, io_done_n, err, err_n, busy, busy_n;
    logic [TIMEOUT_W-1:0]  timer, timer_n;
    logic [7:0]            ack_ext, slot_onehot;
    logic                  ack_s;

    // widen to 8 so any 3-bit slot index is a legal select
    assign ack_ext     = 8'(hps.sd_ack);
    assign ack_s       = ack_ext[slot_r];
    assign slot_onehot = 8'd1 << slot_r;
    assign hps.sd_rd   = rd_req ? slot_onehot[NUM_SLOTS-1:0] : '0;
    assign hps.sd_wr   = wr_req ? slot_onehot[NUM_SLOTS-1:0] : '0;
    assign fsm_state   = state;

    // FSM state and request/status registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            slot_r  <= '0;
            rd_req  <= 1'b0;
            wr_req  <= 1'b0;
            io_done <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_n;
            slot_r  <= slot_n;
            rd_req  <= rd_req_n;
            wr_req  <= wr_req_n;
            io_done <= io_done_n;
            err     <= err_n;
            busy    <= busy_n;
            timer   <= timer_n;
        end
    end

    // FSM next state: request, wait for ack rise (or timeout), wait for ack fall
    always_comb begin
        state_n   = state;
        slot_n    = slot_r;
        rd_req_n  = rd_req;
        wr_req_n  = wr_req;
        io_done_n = io_done;
        err_n     = err;
        busy_n    = busy;
        timer_n   = timer;
        case (state)
            IDLE: begin
                if (block_rd_edge || block_wr_edge) begin
                    if (int'(ctrl_slot) >= NUM_SLOTS) begin
                        io_done_n = 1'b1;
                        err_n     = 1'b1;
                    end else begin
                        slot_n    = ctrl_slot;
                        rd_req_n  = block_rd_edge;
                        wr_req_n  = ~block_rd_edge;
                        io_done_n = 1'b0;
                        err_n     = 1'b0;
                        busy_n    = 1'b1;
                        timer_n   = '0;
                        state_n   = REQ;
                    end
                end
            end
            REQ: begin
                if (ack_s) begin
                    rd_req_n = 1'b0;
                    wr_req_n = 1'b0;
                    state_n  = XFER;
                end else if (&timer) begin
                    rd_req_n  = 1'b0;
                    wr_req_n  = 1'b0;
                    err_n     = 1'b1;
                    io_done_n = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            XFER: begin
                // entered with ack high, so low here means it fell
                if (!ack_s) begin
                    io_done_n = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- mount queue ----------------
    logic [NUM_SLOTS-1:0] mnt_q, mnt_edge, pending, ro_r, pend_clr;
    logic [31:0]          size_r [NUM_SLOTS];
    logic [1:0]           type_r [NUM_SLOTS];
    logic                 outstanding, mnt_toggle, rep_ro, pick_valid, pick_ro, issue;
    slot_t                fileno, pick;
    logic [1:0]           filetype, pick_type;
    logic [31:0]          rep_size, pick_size;
    logic [7:0]           pick_onehot;

    assign mnt_edge    = hps.img_mounted & ~mnt_q;
    assign issue       = ~outstanding & pick_valid;
    assign pick_onehot = 8'd1 << pick;
    assign pend_clr    = issue ? pick_onehot[NUM_SLOTS-1:0] : '0;

    // lowest pending slot (descending scan so the lowest index lands last)
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        pick_ro    = 1'b0;
        pick_type  = '0;
        pick_size  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick       = slot_t'(i);
                pick_valid = 1'b1;
                pick_ro    = ro_r[i];
                pick_type  = type_r[i];
                pick_size  = size_r[i];
            end
        end
    end

    // latch mount data per slot and hand out one report at a time
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mnt_q       <= '0;
            pending     <= '0;
            ro_r        <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                size_r[i] <= '0;
                type_r[i] <= '0;
            end
            outstanding <= 1'b0;
            mnt_toggle  <= 1'b0;
            fileno      <= '0;
            filetype    <= '0;
            rep_ro      <= 1'b0;
            rep_size    <= '0;
        end else begin
            mnt_q   <= hps.img_mounted;
            // a fresh edge re-sets pending even if that slot is reported now
            pending <= (pending & ~pend_clr) | mnt_edge;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (mnt_edge[i]) begin
                    size_r[i] <= hps.img_size[31:0];
                    ro_r[i]   <= hps.img_readonly;
                    type_r[i] <= hps.ioctl_index[7:6];
                end
            end
            if (issue) begin
                fileno      <= pick;
                filetype    <= pick_type;
                rep_ro      <= pick_ro;
                rep_size    <= pick_size;
                mnt_toggle  <= ~mnt_toggle;
                outstanding <= 1'b1;
            end else if (zpu_mnt_ack) begin
                outstanding <= 1'b0;
            end
        end
    end

    // status word and read-data mux
    always_comb begin
        zpu_status                           = '0;
        zpu_status[ST_IO_DONE]               = io_done;
        zpu_status[ST_MNT_TOGGLE]            = mnt_toggle;
        zpu_status[ST_FILENO_LO +: 3]        = fileno;
        zpu_status[ST_FILETYPE_LO +: 2]      = filetype;
        zpu_status[ST_READONLY]              = rep_ro;
        zpu_status[ST_ERR]                   = err;
        zpu_status[ST_BUSY]                  = busy;
    end

    assign zpu_rdata = lba_sel ? rep_size : {24'b0, buf_q};

endmodule
